// File: rtl/suma_mult_pkg.sv
// Shared definitions for the sum-of-multiples result transmitter:
// serializer state encoding, default frame header and state sequencing.
package suma_mult_pkg;

    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;
    localparam int         WORD_W           = 32;

    typedef enum logic [2:0] {
        SER_IDLE = 3'd0,
        SER_HDR  = 3'd1,
        SER_B0   = 3'd2,
        SER_B1   = 3'd3,
        SER_B2   = 3'd4,
        SER_B3   = 3'd5
    } ser_state_e;

    // Successor of a transmitting state once its byte has been accepted.
    function automatic ser_state_e ser_next(input ser_state_e s);
        case (s)
            SER_HDR: return SER_B0;
            SER_B0:  return SER_B1;
            SER_B1:  return SER_B2;
            SER_B2:  return SER_B3;
            default: return SER_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/suma_mult_res_fifo.sv
// Result word FIFO; a push into a full FIFO is taken only when a pop
// happens in the same cycle, otherwise it is ignored.
module suma_mult_res_fifo
    import suma_mult_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WORD_W-1:0]        push_data,
    input  logic                     pop,
    output logic [WORD_W-1:0]        pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q,  level_d;
    logic              push_ok;
    logic              pop_ok;

    assign full     = (level_q == FULL_LVL);
    assign empty    = (level_q == '0);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem_q[rd_ptr_q];
    assign level    = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + (AW + 1)'(1);
            2'b01:   level_d = level_q - (AW + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: level/pointers gate every read.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/suma_mult_result_tx.sv
// Captures each finished sum-of-multiples result on the busy falling edge,
// buffers it and sends it downstream as a 5-byte frame: header then X LSB first.
//
// state | meaning
// IDLE  | no frame in flight; pops the next buffered word when one exists
// HDR   | offering the header byte
// B0-B3 | offering result byte 0..3 (LSB first); B3 accepted ends the frame
module suma_mult_result_tx
    import suma_mult_pkg::*;
#(
    parameter logic [7:0] HDR_BYTE   = HDR_BYTE_DEFAULT,
    parameter int         FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          b,
    input  logic [31:0]                   X,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          overflow,
    output logic [7:0]                    frame_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    ser_state_e  state_q;
    logic        tx_valid_q;
    logic [7:0]  tx_data_q;
    logic [31:0] shift_q;

    logic        b_q, b_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;

    logic        completion;
    logic        xfer;
    logic        frame_done;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_rd_data;

    assign completion = b_q && !b;
    assign xfer       = tx_valid_q && tx_ready;
    assign frame_done = xfer && (state_q == SER_B3);
    assign fifo_pop   = (state_q == SER_IDLE) && !fifo_empty;

    suma_mult_res_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (completion),
        .push_data (X),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_comb begin
        b_d         = b;
        overflow_d  = overflow_q;
        frame_cnt_d = frame_cnt_q;
        // A pop in the same cycle frees a slot, so only a pop-less full push is lost.
        if (completion && fifo_full && !fifo_pop) overflow_d = 1'b1;
        if (frame_done) frame_cnt_d = frame_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_q         <= 1'b0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= 8'h00;
        end else begin
            b_q         <= b_d;
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= SER_IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            shift_q    <= 32'h0;
        end else begin
            case (state_q)
                SER_IDLE: begin
                    if (fifo_pop) begin
                        shift_q    <= fifo_rd_data;
                        tx_data_q  <= HDR_BYTE;
                        tx_valid_q <= 1'b1;
                        state_q    <= SER_HDR;
                    end
                end
                default: begin
                    if (xfer) begin
                        state_q <= ser_next(state_q);
                        if (state_q == SER_B3) begin
                            tx_valid_q <= 1'b0;
                            tx_data_q  <= 8'h00;
                        end else begin
                            tx_data_q <= shift_q[7:0];
                            shift_q   <= {8'h00, shift_q[31:8]};
                        end
                    end
                end
            endcase
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign overflow  = overflow_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_suma_mult_result_tx.sv
// Self-checking bench for suma_mult_result_tx: expected byte streams are built
// from frame rules (header + LSB-first word) and compared with observed transfers.
module tb_suma_mult_result_tx;

    localparam int FD = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              b = 1'b0;
    logic [31:0]       X = 32'h0;
    logic              tx_ready = 1'b0;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              overflow;
    logic [7:0]        frame_cnt;
    logic [$clog2(FD):0] fifo_level;

    int total = 0;
    int passed = 0;
    int hold_err = 0;
    int rdy_mode = 0;
    logic [7:0] fc_model = 8'h00;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    suma_mult_result_tx #(.HDR_BYTE(8'hA5), .FIFO_DEPTH(FD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .b          (b),
        .X          (X),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .overflow   (overflow),
        .frame_cnt  (frame_cnt),
        .fifo_level (fifo_level)
    );

    // Transfer monitor and stall-hold observer
    logic       pv = 1'b0, pr = 1'b0, prst = 1'b0;
    logic [7:0] pd = 8'h00;
    always @(negedge clk) begin
        if (rst_n && prst && pv && !pr && !(tx_valid && tx_data == pd)) hold_err++;
        if (rst_n && tx_valid && tx_ready) got.push_back(tx_data);
        pv = tx_valid; pr = tx_ready; pd = tx_data; prst = rst_n;
    end

    initial forever begin
        @(posedge clk); #1;
        if (rdy_mode == 1) tx_ready = ~tx_ready;
        else if (rdy_mode == 2) tx_ready = 1'($urandom_range(0, 1));
    end

    function automatic void add_frame(input logic [31:0] w);
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
        fc_model = fc_model + 8'd1;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic complete(input logic [31:0] w, input int hold);
        b = 1'b1;
        repeat (hold) begin X = $urandom; tick(); end
        b = 1'b0; X = w;
        tick();
        X = $urandom;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        int quiet = 0;
        while (quiet < 3 && n < budget) begin
            tick(); n++;
            if (!tx_valid && fifo_level == 0) quiet++; else quiet = 0;
        end
        if (quiet < 3) begin
            total++;
            $display("FAIL %s_drain: still busy after %0d cycles, required idle", name, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; b = 1'b0; tx_ready = 1'b0;
        repeat (3) tick();
        total++; if (tx_valid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", tx_valid); else passed++;
        total++; if (tx_data !== 8'h00) $display("FAIL rst_data: got %0h want 00", tx_data); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL rst_ovf: got %0b want 0", overflow); else passed++;
        total++; if (frame_cnt !== 8'h00) $display("FAIL rst_fcnt: got %0d want 0", frame_cnt); else passed++;
        total++; if (fifo_level !== '0) $display("FAIL rst_level: got %0d want 0", fifo_level); else passed++;
        rst_n = 1'b1; fc_model = 8'h00;
        repeat (5) tick();
        total++; if (fifo_level !== '0 || tx_valid !== 1'b0)
            $display("FAIL rst_no_completion: level %0d valid %0b want 0/0", fifo_level, tx_valid); else passed++;
    endtask

    task automatic test_single();
        logic [31:0] w = 32'h12345678;
        logic [7:0] seq [5];
        seq[0] = 8'hA5; seq[1] = 8'h78; seq[2] = 8'h56; seq[3] = 8'h34; seq[4] = 8'h12;
        tx_ready = 1'b1; got.delete(); exp_q.delete();
        b = 1'b1; X = $urandom; tick();
        b = 1'b0; X = w;
        total++; if (tx_valid !== 1'b0) $display("FAIL single_k: valid %0b want 0", tx_valid); else passed++;
        tick(); X = $urandom;
        total++; if (tx_valid !== 1'b0) $display("FAIL single_k1: valid %0b want 0", tx_valid); else passed++;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (tx_valid !== 1'b1 || tx_data !== seq[i])
                $display("FAIL single_byte%0d: valid %0b data %0h want 1/%0h", i, tx_valid, tx_data, seq[i]);
            else passed++;
        end
        tick();
        fc_model = fc_model + 8'd1;
        total++; if (tx_valid !== 1'b0) $display("FAIL single_end: valid %0b want 0", tx_valid); else passed++;
        total++; if (frame_cnt !== fc_model) $display("FAIL single_fcnt: got %0d want %0d", frame_cnt, fc_model); else passed++;
    endtask

    task automatic test_backpressure();
        got.delete(); exp_q.delete(); hold_err = 0;
        rdy_mode = 1;
        complete(32'h12345678, 1); add_frame(32'h12345678);
        wait_idle(200, "bp");
        rdy_mode = 0; tx_ready = 1'b1;
        total++; if (got.size() !== exp_q.size()) $display("FAIL bp_len: got %0d want %0d", got.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            total++; if (got[i] !== exp_q[i]) $display("FAIL bp_byte%0d: got %0h want %0h", i, got[i], exp_q[i]); else passed++;
        end
        total++; if (hold_err !== 0) $display("FAIL bp_hold: %0d stall violations want 0", hold_err); else passed++;
        total++; if (frame_cnt !== fc_model) $display("FAIL bp_fcnt: got %0d want %0d", frame_cnt, fc_model); else passed++;
    endtask

    task automatic test_simultaneous();
        logic [31:0] wa = $urandom, wb = $urandom, wc = $urandom, wd = $urandom;
        got.delete(); exp_q.delete();
        tx_ready = 1'b0;
        complete(wa, 1); complete(wb, 1); complete(wc, 1);
        total++; if (fifo_level !== 2) $display("FAIL sim_full: level %0d want 2", fifo_level); else passed++;
        tx_ready = 1'b1;
        repeat (4) tick();
        b = 1'b1;
        tick();
        b = 1'b0; X = wd;
        total++; if (tx_valid !== 1'b0) $display("FAIL sim_idle_gap: valid %0b want 0", tx_valid); else passed++;
        tick(); X = $urandom;
        total++; if (fifo_level !== 2) $display("FAIL sim_level: got %0d want 2", fifo_level); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL sim_ovf: got %0b want 0", overflow); else passed++;
        add_frame(wa); add_frame(wb); add_frame(wc); add_frame(wd);
        wait_idle(200, "sim");
        total++; if (got.size() !== exp_q.size()) $display("FAIL sim_len: got %0d want %0d", got.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            total++; if (got[i] !== exp_q[i]) $display("FAIL sim_byte%0d: got %0h want %0h", i, got[i], exp_q[i]); else passed++;
        end
    endtask

    task automatic test_overflow();
        logic [31:0] wp = $urandom;
        got.delete(); exp_q.delete();
        tx_ready = 1'b0;
        complete(wp, 1);
        complete(32'd1, 1); complete(32'd2, 1); complete(32'd3, 1);
        tick();
        total++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %0b want 1", overflow); else passed++;
        total++; if (fifo_level !== 2) $display("FAIL ovf_level: got %0d want 2", fifo_level); else passed++;
        tx_ready = 1'b1;
        add_frame(wp); add_frame(32'd1); add_frame(32'd2);
        wait_idle(200, "ovf");
        total++; if (got.size() !== exp_q.size()) $display("FAIL ovf_len: got %0d want %0d", got.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            total++; if (got[i] !== exp_q[i]) $display("FAIL ovf_byte%0d: got %0h want %0h", i, got[i], exp_q[i]); else passed++;
        end
        total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %0b want 1", overflow); else passed++;
        total++; if (frame_cnt !== fc_model) $display("FAIL ovf_fcnt: got %0d want %0d", frame_cnt, fc_model); else passed++;
    endtask

    task automatic test_reset_midframe();
        logic [31:0] w1 = $urandom;
        tx_ready = 1'b1;
        complete(w1, 1);
        b = 1'b1; tick();
        b = 1'b0; X = $urandom; tick();
        X = $urandom; tick();
        total++; if (tx_data !== w1[15:8] || fifo_level !== 1)
            $display("FAIL mid_b1: data %0h level %0d want %0h/1", tx_data, fifo_level, w1[15:8]); else passed++;
        rst_n = 1'b0;
        tick();
        total++; if (tx_valid !== 1'b0) $display("FAIL mid_valid: got %0b want 0", tx_valid); else passed++;
        total++; if (fifo_level !== '0) $display("FAIL mid_level: got %0d want 0", fifo_level); else passed++;
        total++; if (overflow !== 1'b0 || frame_cnt !== 8'h00)
            $display("FAIL mid_clear: ovf %0b fcnt %0d want 0/0", overflow, frame_cnt); else passed++;
        rst_n = 1'b1; fc_model = 8'h00;
        got.delete();
        repeat (10) tick();
        total++; if (got.size() !== 0) $display("FAIL mid_silent: %0d bytes want 0", got.size()); else passed++;
    endtask

    task automatic test_random();
        logic [31:0] w;
        got.delete(); exp_q.delete();
        rdy_mode = 2;
        for (int burst = 0; burst < 12; burst++) begin
            int nb = $urandom_range(1, 3);
            for (int j = 0; j < nb; j++) begin
                w = $urandom;
                complete(w, $urandom_range(1, 6));
                add_frame(w);
            end
            wait_idle(400, "rand");
        end
        rdy_mode = 0; tx_ready = 1'b1;
        total++; if (got.size() !== exp_q.size()) $display("FAIL rand_len: got %0d want %0d", got.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            total++; if (got[i] !== exp_q[i]) $display("FAIL rand_byte%0d: got %0h want %0h", i, got[i], exp_q[i]); else passed++;
        end
        total++; if (overflow !== 1'b0) $display("FAIL rand_ovf: got %0b want 0", overflow); else passed++;
        total++; if (frame_cnt !== fc_model) $display("FAIL rand_fcnt: got %0d want %0d", frame_cnt, fc_model); else passed++;
    endtask

    task automatic test_wrap();
        rst_n = 1'b0; tick(); rst_n = 1'b1; fc_model = 8'h00;
        tx_ready = 1'b1; got.delete();
        for (int i = 0; i < 255; i++) begin
            complete($urandom, 1);
            wait_idle(100, "wrap");
        end
        total++; if (frame_cnt !== 8'd255) $display("FAIL wrap_255: got %0d want 255", frame_cnt); else passed++;
        complete($urandom, 1);
        wait_idle(100, "wrap");
        total++; if (frame_cnt !== 8'd0) $display("FAIL wrap_zero: got %0d want 0", frame_cnt); else passed++;
        total++; if (got.size() !== 256 * 5) $display("FAIL wrap_bytes: got %0d want %0d", got.size(), 256 * 5); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_simultaneous();
        test_overflow();
        test_reset_midframe();
        test_random();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
